mdu_issue_ctrl: RTL and testbench

- Execute-stage controller that sits directly upstream of the radix-4 Booth multi-cycle multiplier.
- Accepts decoded RV64M multiply ops (MUL/MULH/MULHSU/MULHU/MULW) from the ID/EX register with a valid/ready handshake.
- Issues each op to the multiplier, waits for completion, and holds the result for writeback with a valid/ready handshake.
- Handles pipeline flush (including draining an in-flight multiply) and short-circuits zero operands without using the multiplier.

---
 rtl/mdu_issue_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: execute-stage controller in front of the multi-cycle Booth
// multiplier. It accepts one decoded RV64M multiply at a time, issues it to the
// multiplier, collects the result and holds it for writeback. It also handles
// flush, including draining a multiply that is already running, and skips the
// multiplier entirely when either operand is zero.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_*                 op from ID/EX (valid/ready, funct3, word flag, rd, rs1/rs2)
//   flush                kill the current op (branch/trap)
//   out_*                result to writeback (valid/ready, data, rd)
//   busy                 high whenever an op is held (pipeline stall)
//   mult_valid/type/a/b  start request and operands to the multiplier
//   mult_result_ready    result consumed (mirrors mult_result_ok in WAIT/DRAIN)
//   mult_out/result_ok   multiplier result and its valid flag
module mdu_issue_ctrl #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned RD_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic            in_word,
   input  logic [RD_W-1:0] in_rd,
   input  logic [XLEN-1:0] in_src1,
   input  logic [XLEN-1:0] in_src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [RD_W-1:0] out_rd,
   output logic            busy,
   output logic            mult_valid,
   output logic [4:0]      mult_type,
   output logic [XLEN-1:0] mult_a,
   output logic [XLEN-1:0] mult_b,
   output logic            mult_result_ready,
   input  logic [XLEN-1:0] mult_out,
   input  logic            mult_result_ok
);

   localparam int unsigned TYPE_W = 5;
   localparam int unsigned HALF_W = 32;

   localparam logic [TYPE_W-1:0] T_MUL    = TYPE_W'(5'b00001);
   localparam logic [TYPE_W-1:0] T_MULH   = TYPE_W'(5'b00010);
   localparam logic [TYPE_W-1:0] T_MULHSU = TYPE_W'(5'b00100);
   localparam logic [TYPE_W-1:0] T_MULHU  = TYPE_W'(5'b01000);
   localparam logic [TYPE_W-1:0] T_MULW   = TYPE_W'(5'b10000);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_OUT   = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [TYPE_W-1:0] type_q, type_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]   data_q, data_d;

   logic              accept_c;
   logic              zero_op_c;

   // funct3 to one-hot multiplier type; bit 2 set is illegal upstream and falls back to MUL
   function automatic logic [TYPE_W-1:0] decode_type(input logic [2:0] op, input logic word);
      logic [TYPE_W-1:0] t;
      t = T_MUL;
      if (word) begin
         t = T_MULW;
      end else if (!op[2]) begin
         case (op[1:0])
            2'b01:   t = T_MULH;
            2'b10:   t = T_MULHSU;
            2'b11:   t = T_MULHU;
            default: t = T_MUL;
         endcase
      end
      return t;
   endfunction

   assign accept_c = in_valid & in_ready;

   // MULW only consumes the low word, so only the low word decides the bypass
   assign zero_op_c = in_word
                    ? ((in_src1[HALF_W-1:0] == '0) || (in_src2[HALF_W-1:0] == '0))
                    : ((in_src1 == '0) || (in_src2 == '0));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched op and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         type_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rd_q   <= '0;
         data_q <= '0;
      end else begin
         type_q <= type_d;
         a_q    <= a_d;
         b_q    <= b_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               type_d = decode_type(in_op, in_word);
               a_d    = in_src1;
               b_d    = in_src2;
               rd_d   = in_rd;
               if (zero_op_c) begin
                  data_d  = '0;
                  state_d = S_OUT;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            state_d = flush ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            // a result arriving together with flush is consumed and dropped
            if (mult_result_ok) begin
               if (flush) begin
                  state_d = S_IDLE;
               end else begin
                  data_d  = mult_out;
                  state_d = S_OUT;
               end
            end else if (flush) begin
               state_d = S_DRAIN;
            end
         end
         S_OUT: begin
            if (flush || out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (mult_result_ok) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      in_ready          = 1'b0;
      mult_valid        = 1'b0;
      mult_result_ready = 1'b0;
      out_valid         = 1'b0;
      busy              = (state_q != S_IDLE);
      case (state_q)
         S_IDLE:          in_ready          = rst_n & ~flush;
         S_ISSUE:         mult_valid        = ~flush;
         S_WAIT, S_DRAIN: mult_result_ready = mult_result_ok;
         S_OUT:           out_valid         = 1'b1;
         default:         ;
      endcase
   end

   assign mult_type = type_q;
   assign mult_a    = a_q;
   assign mult_b    = b_q;
   assign out_data  = data_q;
   assign out_rd    = rd_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a behavioural multiplier model.
module tb_mdu_issue_ctrl;

   localparam int unsigned XLEN = 64;
   localparam int unsigned RD_W = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_op;
   logic            in_word;
   logic [RD_W-1:0] in_rd;
   logic [XLEN-1:0] in_src1;
   logic [XLEN-1:0] in_src2;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;
   logic [RD_W-1:0] out_rd;
   logic            busy;
   logic            mult_valid;
   logic [4:0]      mult_type;
   logic [XLEN-1:0] mult_a;
   logic [XLEN-1:0] mult_b;
   logic            mult_result_ready;
   logic [XLEN-1:0] mult_out = '0;
   logic            mult_result_ok = 1'b0;

   mdu_issue_ctrl #(.XLEN(XLEN), .RD_W(RD_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_op             (in_op),
      .in_word           (in_word),
      .in_rd             (in_rd),
      .in_src1           (in_src1),
      .in_src2           (in_src2),
      .flush             (flush),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_rd            (out_rd),
      .busy              (busy),
      .mult_valid        (mult_valid),
      .mult_type         (mult_type),
      .mult_a            (mult_a),
      .mult_b            (mult_b),
      .mult_result_ready (mult_result_ready),
      .mult_out          (mult_out),
      .mult_result_ok    (mult_result_ok)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- multiplier model ----------------
   int          lat_cfg = 0;
   int          mv_total = 0;
   bit          start_seen = 1'b0;
   bit          done_seen = 1'b0;
   bit          pending = 1'b0;
   int          cnt = 0;
   logic [63:0] res_pend = '0;

   function automatic logic [63:0] ref_mult(input logic [4:0] t, input logic [63:0] a,
                                            input logic [63:0] b);
      logic [127:0] ua, ub, p;
      case (t)
         5'b00010: begin ua = {{64{a[63]}}, a}; ub = {{64{b[63]}}, b}; end
         5'b00100: begin ua = {{64{a[63]}}, a}; ub = {64'd0, b}; end
         default:  begin ua = {64'd0, a};       ub = {64'd0, b}; end
      endcase
      p = ua * ub;
      case (t)
         5'b00001: return p[63:0];
         5'b10000: return {{32{p[31]}}, p[31:0]};
         default:  return p[127:64];
      endcase
   endfunction

   // observe what the DUT presents during the cycle
   always @(negedge clk) begin
      start_seen = mult_valid;
      done_seen  = mult_result_ready && mult_result_ok;
      if (mult_valid) begin
         mv_total = mv_total + 1;
         res_pend = ref_mult(mult_type, mult_a, mult_b);
      end
   end

   // result appears lat_cfg cycles into WAIT and holds until consumed
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         mult_result_ok = 1'b0;
         pending        = 1'b0;
      end else begin
         if (done_seen) begin
            mult_result_ok = 1'b0;
            mult_out       = '0;
         end
         if (start_seen) begin
            pending = 1'b1;
            cnt     = lat_cfg;
         end
         if (pending && !mult_result_ok) begin
            if (cnt == 0) begin
               mult_result_ok = 1'b1;
               mult_out       = res_pend;
               pending        = 1'b0;
            end else begin
               cnt = cnt - 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready)
         assert (!in_op[2]) else $error("protocol: funct3 bit 2 set on an accepted op");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [2:0] op, input logic word, input logic [4:0] rd,
                           input logic [63:0] s1, input logic [63:0] s2);
      in_valid = 1'b1;
      in_op    = op;
      in_word  = word;
      in_rd    = rd;
      in_src1  = s1;
      in_src2  = s2;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         cyc();
         mid();
         n++;
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic        word;
      logic [4:0]  rd;
      logic [63:0] s1;
      logic [63:0] s2;
      int          lat;
      logic [63:0] exp_data;
      logic [4:0]  exp_type;
      bit          zero;
   } vec_t;

   vec_t vecs[8];

   // one full op: accept, check issue/bypass cycle, wait, check result, handshake
   task automatic run_op(input vec_t v);
      int base;
      int n;
      base    = mv_total;
      lat_cfg = v.lat;
      drive_op(v.op, v.word, v.rd, v.s1, v.s2);
      out_ready = 1'b0;
      #1;
      check("accept_in_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      mid();
      check("t1_busy", busy, 1);
      if (v.zero) begin
         check("bypass_out_valid_t1", out_valid, 1);
         check("bypass_out_data", out_data, 0);
         check("bypass_mult_valid", mult_valid, 0);
      end else begin
         check("issue_mult_valid", mult_valid, 1);
         check("issue_mult_type", mult_type, v.exp_type);
         check("issue_mult_a", mult_a, v.s1);
         check("issue_mult_b", mult_b, v.s2);
         check("issue_in_ready", in_ready, 0);
      end
      wait_out(n);
      if (!v.zero) check("result_latency", n, 2 + v.lat);
      check("out_valid", out_valid, 1);
      check("out_data", out_data, v.exp_data);
      check("out_rd", out_rd, v.rd);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      mid();
      check("post_busy", busy, 0);
      check("post_out_valid", out_valid, 0);
      check("mult_start_count", mv_total - base, v.zero ? 0 : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      bit seen_out;

      vecs[0] = '{3'b000, 1'b0, 5'd7,  64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2,
                  64'hFFFF_FFFF_FFFF_FFF1, 5'b00001, 1'b0};
      vecs[1] = '{3'b011, 1'b0, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0,
                  64'hFFFF_FFFF_FFFF_FFFE, 5'b01000, 1'b0};
      vecs[2] = '{3'b001, 1'b0, 5'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3,
                  64'd0, 5'b00010, 1'b0};
      vecs[3] = '{3'b000, 1'b1, 5'd3,  64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 1,
                  64'hFFFF_FFFF_FFFF_FFFE, 5'b10000, 1'b0};
      vecs[4] = '{3'b001, 1'b0, 5'd9,  64'h55, 64'd0, 0, 64'd0, 5'b00010, 1'b1};
      vecs[5] = '{3'b000, 1'b1, 5'd10, 64'h1234_5678_0000_0000, 64'd5, 0,
                  64'd0, 5'b10000, 1'b1};
      vecs[6] = '{3'b010, 1'b0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1,
                  64'hFFFF_FFFF_FFFF_FFFF, 5'b00100, 1'b0};
      vecs[7] = '{3'b000, 1'b0, 5'd12, 64'h1_0000_0000, 64'd3, 0,
                  64'h3_0000_0000, 5'b00001, 1'b0};

      rst_n = 1'b0; in_valid = 1'b1; in_op = 3'b000; in_word = 1'b0; in_rd = '0;
      in_src1 = 64'd1; in_src2 = 64'd1; flush = 1'b0; out_ready = 1'b0;

      // reset state, with in_valid high to show in_ready is held low
      cyc();
      cyc();
      mid();
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_mult_valid", mult_valid, 0);
      check("rst_mult_rr", mult_result_ready, 0);
      check("rst_mult_type", mult_type, 0);
      check("rst_mult_a", mult_a, 0);
      check("rst_mult_b", mult_b, 0);
      in_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      mid();
      check("idle_in_ready", in_ready, 1);
      flush = 1'b1;
      #1;
      check("idle_flush_in_ready", in_ready, 0);
      flush = 1'b0;
      #1;

      for (int i = 0; i < 8; i++) run_op(vecs[i]);

      // flush in ISSUE: multiplier never started
      base = mv_total;
      lat_cfg = 0;
      drive_op(3'b000, 1'b0, 5'd4, 64'd4, 64'd4);
      cyc();
      in_valid = 1'b0;
      flush = 1'b1;
      mid();
      check("issue_flush_mult_valid", mult_valid, 0);
      cyc();
      flush = 1'b0;
      mid();
      check("issue_flush_busy", busy, 0);
      check("issue_flush_starts", mv_total - base, 0);

      // flush in WAIT before the result: drain it silently
      base = mv_total;
      lat_cfg = 4;
      drive_op(3'b000, 1'b0, 5'd5, 64'd5, 64'd7);
      cyc();
      in_valid = 1'b0;
      cyc();
      flush = 1'b1;
      mid();
      check("wait_flush_rr", mult_result_ready, 0);
      cyc();
      flush = 1'b0;
      mid();
      check("drain_busy", busy, 1);
      check("drain_out_valid", out_valid, 0);
      check("drain_in_ready", in_ready, 0);
      seen_out = 1'b0;
      n = 0;
      while (!mult_result_ok && n < 20) begin
         cyc();
         mid();
         if (out_valid) seen_out = 1'b1;
         n++;
      end
      check("drain_rr", mult_result_ready, 1);
      check("drain_no_out", seen_out, 0);
      cyc();
      mid();
      check("drain_exit_busy", busy, 0);
      check("drain_exit_out_valid", out_valid, 0);
      check("drain_starts", mv_total - base, 1);
      run_op('{3'b000, 1'b0, 5'd6, 64'd6, 64'd7, 1, 64'd42, 5'b00001, 1'b0});

      // flush in WAIT together with the result: consumed and dropped
      lat_cfg = 0;
      drive_op(3'b000, 1'b0, 5'd8, 64'd8, 64'd8);
      cyc();
      in_valid = 1'b0;
      cyc();
      flush = 1'b1;
      mid();
      check("wait_flush_ok_rr", mult_result_ready, 1);
      cyc();
      flush = 1'b0;
      mid();
      check("wait_flush_ok_busy", busy, 0);
      check("wait_flush_ok_out_valid", out_valid, 0);

      // writeback backpressure: result held, no new op accepted
      base = mv_total;
      lat_cfg = 1;
      drive_op(3'b000, 1'b0, 5'd13, 64'd9, 64'd9);
      cyc();
      in_valid = 1'b0;
      mid();
      wait_out(n);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_out_data", out_data, 64'd81);
         check("bp_in_ready", in_ready, 0);
         check("bp_busy", busy, 1);
         drive_op(3'b011, 1'b0, 5'd14, 64'd2, 64'd2);
         cyc();
         mid();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      mid();
      check("bp_release_busy", busy, 0);
      check("bp_release_out_valid", out_valid, 0);
      check("bp_starts", mv_total - base, 1);

      // flush in OUT drops the result even with out_ready high
      lat_cfg = 0;
      drive_op(3'b000, 1'b0, 5'd15, 64'd2, 64'd3);
      cyc();
      in_valid = 1'b0;
      mid();
      wait_out(n);
      check("fo_out_data", out_data, 64'd6);
      out_ready = 1'b1;
      flush = 1'b1;
      cyc();
      out_ready = 1'b0;
      flush = 1'b0;
      mid();
      check("fo_out_valid", out_valid, 0);
      check("fo_busy", busy, 0);

      // reset while a multiply is outstanding
      lat_cfg = 5;
      drive_op(3'b000, 1'b0, 5'd16, 64'd9, 64'd9);
      cyc();
      in_valid = 1'b0;
      cyc();
      rst_n = 1'b0;
      cyc();
      mid();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_mult_a", mult_a, 0);
      check("mid_rst_mult_type", mult_type, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      cyc();
      mid();
      run_op(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
